// File: rtl/modulo_capture_buffer.sv
// Up/down modulo counter that captures data_in into a circular FIFO on every wrap,
// with registered read port, level/full/empty flags and a sticky overflow flag.
module modulo_capture_buffer #(
  parameter int MODULO    = 10,
  parameter int WIDTH     = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int OVERWRITE = 0,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              up_dn,
  input  logic              clr,
  output logic [WIDTH-1:0]  count,
  output logic              tick,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam logic [WIDTH-1:0] LAST     = WIDTH'(MODULO - 1);
  localparam logic [ADDR_W:0]  LVL_FULL = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  count_q, count_d;
  logic              tick_q, tick_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [WIDTH-1:0]  terminal;
  logic              wrap, do_rd, full_blk, do_wr, ovw, mem_we;

  always_comb begin
    terminal = up_dn ? LAST : '0;
    wrap     = en && (count_q == terminal);
    do_rd    = rd_en && !empty_q;
    // A same-cycle read frees a slot, so a full buffer only blocks when nothing is read.
    full_blk = full_q && !do_rd;
    do_wr    = wrap && (!full_blk || (OVERWRITE != 0));
    ovw      = wrap && full_blk && (OVERWRITE != 0);
    mem_we   = do_wr && !clr;

    count_d    = count_q;
    tick_d     = tick_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    full_d     = full_q;
    empty_d    = empty_q;
    ovf_d      = ovf_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;

    if (clr) begin
      count_d  = '0;
      tick_d   = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      full_d   = 1'b0;
      empty_d  = 1'b1;
      ovf_d    = 1'b0;
    end else begin
      tick_d = wrap;
      if (en) begin
        if (wrap)       count_d = up_dn ? '0 : LAST;
        else if (up_dn) count_d = count_q + 1'b1;
        else            count_d = count_q - 1'b1;
      end
      if (do_wr)        wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd || ovw) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wrap && full_blk) ovf_d = 1'b1;
      if (do_rd) begin
        rd_valid_d = 1'b1;
        rd_data_d  = mem_q[rd_ptr_q];
      end
      level_d = level_q + (ADDR_W + 1)'(do_wr && !ovw) - (ADDR_W + 1)'(do_rd);
      full_d  = (level_d == LVL_FULL);
      empty_d = (level_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      tick_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      count_q    <= count_d;
      tick_q     <= tick_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= data_in;
  end

  assign count    = count_q;
  assign tick     = tick_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign level    = level_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_modulo_capture_buffer.sv
// Scoreboard bench: drop-newest and overwrite-oldest instances driven with identical stimulus.
module tb_modulo_capture_buffer;

  logic       clk = 1'b0;
  logic       rst_n, en, up_dn, clr, rd_en;
  logic [7:0] data_in;

  logic [2:0] count0, count1;
  logic       tick0, tick1, rv0, rv1, full0, full1, empty0, empty1, ovf0, ovf1;
  logic [7:0] rd0, rd1;
  logic [2:0] lvl0, lvl1;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  modulo_capture_buffer #(.MODULO(5), .WIDTH(3), .DATA_W(8), .DEPTH(4), .OVERWRITE(0)) u_drop (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr),
    .count(count0), .tick(tick0), .data_in(data_in), .rd_en(rd_en),
    .rd_data(rd0), .rd_valid(rv0), .level(lvl0), .full(full0), .empty(empty0),
    .overflow(ovf0));

  modulo_capture_buffer #(.MODULO(5), .WIDTH(3), .DATA_W(8), .DEPTH(4), .OVERWRITE(1)) u_ovw (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr),
    .count(count1), .tick(tick1), .data_in(data_in), .rd_en(rd_en),
    .rd_data(rd1), .rd_valid(rv1), .level(lvl1), .full(full1), .empty(empty1),
    .overflow(ovf1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int cnt, input bit tk, input int lvl,
                           input bit ov);
    chk({tag, " count0"}, 32'(count0), 32'(cnt));
    chk({tag, " count1"}, 32'(count1), 32'(cnt));
    chk({tag, " tick0"},  32'(tick0),  32'(tk));
    chk({tag, " tick1"},  32'(tick1),  32'(tk));
    chk({tag, " level0"}, 32'(lvl0),   32'(lvl));
    chk({tag, " level1"}, 32'(lvl1),   32'(lvl));
    chk({tag, " full0"},  32'(full0),  32'(lvl == 4));
    chk({tag, " full1"},  32'(full1),  32'(lvl == 4));
    chk({tag, " empty0"}, 32'(empty0), 32'(lvl == 0));
    chk({tag, " empty1"}, 32'(empty1), 32'(lvl == 0));
    chk({tag, " ovf0"},   32'(ovf0),   32'(ov));
    chk({tag, " ovf1"},   32'(ovf1),   32'(ov));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented read must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rv0) begin
        if (q0.size() == 0) chk("rd_valid0 unexpected", 32'(rv0), 32'd0);
        else chk("rd_data0", 32'(rd0), 32'(q0.pop_front()));
      end
      if (rv1) begin
        if (q1.size() == 0) chk("rd_valid1 unexpected", 32'(rv1), 32'd0);
        else chk("rd_data1", 32'(rd1), 32'(q1.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired: sim time %0t, limit 200000", $time);
    $fatal(1, "watchdog");
  end

  int dn_cnt [9] = '{4, 3, 2, 1, 0, 0, 0, 0, 4};
  bit dn_tick[9] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
  bit dn_en  [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 1};
  int dn_lvl [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 2};

  initial begin
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; rd_en = 1'b0; data_in = 8'h00;
    #12;
    chk_state("reset", 0, 0, 0, 0);
    chk("reset rv0", 32'(rv0), 0);
    chk("reset rv1", 32'(rv1), 0);
    chk("reset rd0", 32'(rd0), 0);
    chk("reset rd1", 32'(rd1), 0);
    rst_n = 1'b1;

    // Up count: four wraps fill, 5th wrap with read (accepted), 6th wrap hits full buffer.
    en = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      data_in = 8'hA0 + 8'((e - 1) / 5);
      rd_en = (e == 25);
      if (rd_en) begin
        q0.push_back(8'hA0);
        q1.push_back(8'hA0);
      end
      step();
      chk_state("up", e % 5, (e % 5) == 0, (e / 5 > 4) ? 4 : e / 5, e == 30);
    end

    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rd_en = 1'b1;
      q0.push_back(8'hA1 + 8'(k));
      q1.push_back(8'hA2 + 8'(k));
      step();
      chk_state("drain", 0, 0, 3 - k, 1);
    end
    step();
    chk_state("rd_empty", 0, 0, 0, 1);
    rd_en = 1'b0;
    step();
    chk("hold rd0", 32'(rd0), 32'hA4);
    chk("hold rd1", 32'(rd1), 32'hA5);
    chk("hold rv0", 32'(rv0), 0);

    // Refill two entries, then clear mid-count with overflow set.
    en = 1'b1; up_dn = 1'b1; data_in = 8'hC0;
    for (int e = 1; e <= 12; e++) begin
      step();
      chk_state("pre_clr", e % 5, (e % 5) == 0, e / 5, 1);
    end
    clr = 1'b1; rd_en = 1'b1;
    step();
    chk_state("clr", 0, 0, 0, 0);
    clr = 1'b0; rd_en = 1'b0;

    // Down count with an en=0 gap at the terminal value.
    up_dn = 1'b0;
    for (int i = 0; i < 9; i++) begin
      en = dn_en[i];
      data_in = (i == 8) ? 8'hD1 : 8'hD0;
      step();
      chk_state("down", dn_cnt[i], dn_tick[i], dn_lvl[i], 0);
    end

    en = 1'b0; rd_en = 1'b1;
    q0.push_back(8'hD0);
    q1.push_back(8'hD0);
    step();
    chk_state("rd_d0", 4, 0, 1, 0);

    // Read of D1 is in flight when reset hits; it must vanish.
    step();
    rst_n = 1'b0;
    #1;
    chk_state("rst_mid", 0, 0, 0, 0);
    chk("rst_mid rv0", 32'(rv0), 0);
    chk("rst_mid rv1", 32'(rv1), 0);
    chk("rst_mid rd0", 32'(rd0), 0);
    chk("rst_mid rd1", 32'(rd1), 0);
    rd_en = 1'b0;
    #20;
    rst_n = 1'b1;
    step();
    step();
    chk("q0 drained", 32'(q0.size()), 0);
    chk("q1 drained", 32'(q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
